// File: rtl/ahb_lite_protocol_checker.sv
// Passive AHB-Lite protocol checker: snoops one master/slave link, tracks bursts,
// wait states and two-cycle error responses, and flags violations one cycle after the edge.
module ahb_lite_protocol_checker #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [2:0]            Hburst,
  input  logic [2:0]            Hsize,
  input  logic [1:0]            Htrans,
  input  logic                  Hwrite,
  input  logic                  Hready,
  input  logic                  Hresp,
  output logic [9:0]            err_vec,
  output logic                  err_valid,
  output logic [3:0]            err_first,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  burst_active,
  output logic [4:0]            beat_cnt
);

  localparam int unsigned NUM_CHECKS = 10;
  localparam int unsigned WAIT_W     = $clog2(MAX_WAIT + 2);

  localparam int unsigned CHK_ALIGN       = 0;
  localparam int unsigned CHK_SIZE        = 1;
  localparam int unsigned CHK_ORPHAN_SEQ  = 2;
  localparam int unsigned CHK_SEQ_ADDR    = 3;
  localparam int unsigned CHK_EARLY_TERM  = 4;
  localparam int unsigned CHK_OVERRUN     = 5;
  localparam int unsigned CHK_KB_CROSS    = 6;
  localparam int unsigned CHK_WAIT_STABLE = 7;
  localparam int unsigned CHK_TIMEOUT     = 8;
  localparam int unsigned CHK_RESP_SHAPE  = 9;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] BURST_SINGLE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_t;

  // Beats in a fixed burst; 0 marks the undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b)
      3'd0:       burst_len = 5'd1;
      3'd1:       burst_len = 5'd0;
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      default:    burst_len = 5'd16;
    endcase
  endfunction

  // Next beat address; wrapping bursts stay inside an n*size aligned window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            s,
                                                      input logic [2:0]            b);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << s;
    inc  = a + step;
    mask = '0;
    if (b[2:1] != 2'b00 && !b[0]) begin
      mask      = (step << (3'(b[2:1]) + 3'd1)) - ADDR_WIDTH'(1);
      next_addr = (a & ~mask) | (inc & mask);
    end else begin
      next_addr = inc;
    end
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_burst;
  logic [2:0]              r_size;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_exp_addr;
  logic [4:0]              r_beat_cnt;
  logic                    r_burst_active;
  logic                    r_done_fixed;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic                    r_prev_wait;
  logic [1:0]              r_prev_trans;
  logic [ADDR_WIDTH-1:0]   r_prev_addr;
  logic [2:0]              r_prev_size;
  logic [2:0]              r_prev_burst;
  logic                    r_prev_write;
  logic [NUM_CHECKS-1:0]   r_err_vec;
  logic                    r_err_valid;
  logic [3:0]              r_err_first;
  logic [CNT_WIDTH-1:0]    r_err_count;

  logic                    w_accept;
  logic                    w_acc_ns;
  logic                    w_acc_seq;
  logic                    w_in_burst;
  logic                    w_idle_like;
  logic                    w_err_entry;
  logic [4:0]              w_len;
  logic                    w_seq_last;
  logic [ADDR_WIDTH-1:0]   w_step;
  logic [ADDR_WIDTH-1:0]   w_incr_addr;
  logic                    w_kb;
  logic                    w_overrun;
  logic                    w_changed;
  logic [NUM_CHECKS-1:0]   w_err;
  logic [3:0]              w_first;

  assign w_accept    = Hready && Htrans[1];
  assign w_acc_ns    = w_accept && (Htrans == TR_NONSEQ);
  assign w_acc_seq   = w_accept && (Htrans == TR_SEQ);
  assign w_in_burst  = (r_state == ST_BURST);
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_err_entry = Hresp && !Hready;
  assign w_len       = burst_len(r_burst);
  assign w_seq_last  = (w_len != 5'd0) && ((r_beat_cnt + 5'd1) == w_len);
  assign w_step      = ADDR_WIDTH'(1) << Hsize;
  assign w_incr_addr = Haddr + w_step;
  assign w_kb        = (w_incr_addr[ADDR_WIDTH-1:10] != Haddr[ADDR_WIDTH-1:10]);
  assign w_overrun   = w_acc_seq && r_done_fixed;
  assign w_changed   = (Htrans != r_prev_trans) || (Haddr != r_prev_addr) ||
                       (Hsize != r_prev_size) || (Hburst != r_prev_burst) ||
                       (Hwrite != r_prev_write);

  // Per-edge rule checks.
  always_comb begin
    w_err = '0;
    w_err[CHK_ALIGN]       = w_accept && ((Haddr & (w_step - ADDR_WIDTH'(1))) != '0);
    w_err[CHK_SIZE]        = w_accept && ((32'd8 << Hsize) > 32'(DATA_WIDTH));
    w_err[CHK_ORPHAN_SEQ]  = w_idle_like && Hready && !w_overrun &&
                             ((Htrans == TR_SEQ) || (Htrans == TR_BUSY));
    w_err[CHK_SEQ_ADDR]    = w_acc_seq && w_in_burst &&
                             ((Haddr != r_exp_addr) || (Hsize != r_size) ||
                              (Hwrite != r_write) || (Hburst != r_burst));
    w_err[CHK_EARLY_TERM]  = w_in_burst && Hready && (w_len != 5'd0) &&
                             ((Htrans == TR_IDLE) || (Htrans == TR_NONSEQ));
    w_err[CHK_OVERRUN]     = w_overrun;
    // The final beat of a fixed burst never issues its computed next address.
    w_err[CHK_KB_CROSS]    = w_kb && ((w_acc_ns && Hburst[0]) ||
                                      (w_acc_seq && w_in_burst && r_burst[0] && !w_seq_last));
    w_err[CHK_WAIT_STABLE] = r_prev_wait && w_changed &&
                             (r_state != ST_ERR1) && (r_state != ST_ERR2);
    w_err[CHK_TIMEOUT]     = !Hready && (r_wait_cnt == WAIT_W'(MAX_WAIT));
    w_err[CHK_RESP_SHAPE]  = (Hresp && Hready && (r_state != ST_ERR1)) ||
                             ((r_state == ST_ERR1) && !Hresp);
  end

  always_comb begin
    w_first = 4'hF;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (w_err[i]) w_first = 4'(i);
    end
  end

  // Next-state logic; an ERROR first cycle overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_acc_ns && (Hburst != BURST_SINGLE)) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (Hready) begin
          if (Htrans == TR_IDLE) begin
            w_state_nxt = ST_IDLE;
          end else if (Htrans == TR_NONSEQ) begin
            w_state_nxt = (Hburst != BURST_SINGLE) ? ST_BURST : ST_IDLE;
          end else if ((Htrans == TR_SEQ) && w_seq_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
    endcase
    if (w_err_entry) w_state_nxt = ST_ERR1;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state        <= ST_IDLE;
      r_burst        <= '0;
      r_size         <= '0;
      r_write        <= 1'b0;
      r_exp_addr     <= '0;
      r_beat_cnt     <= '0;
      r_burst_active <= 1'b0;
      r_done_fixed   <= 1'b0;
      r_wait_cnt     <= '0;
      r_prev_wait    <= 1'b0;
      r_prev_trans   <= '0;
      r_prev_addr    <= '0;
      r_prev_size    <= '0;
      r_prev_burst   <= '0;
      r_prev_write   <= 1'b0;
      r_err_vec      <= '0;
      r_err_valid    <= 1'b0;
      r_err_first    <= 4'hF;
      r_err_count    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_burst_active <= (w_state_nxt == ST_BURST);
      r_err_vec      <= w_err;
      r_err_valid    <= |w_err;
      if (|w_err && (r_err_first == 4'hF)) r_err_first <= w_first;
      if (|w_err && (r_err_count != '1))   r_err_count <= r_err_count + CNT_WIDTH'(1);

      if (w_err_entry) begin
        r_beat_cnt <= '0;
      end else if (w_acc_ns) begin
        r_beat_cnt <= 5'd1;
        r_burst    <= Hburst;
        r_size     <= Hsize;
        r_write    <= Hwrite;
        r_exp_addr <= next_addr(Haddr, Hsize, Hburst);
      end else if (w_acc_seq && w_in_burst) begin
        if (r_beat_cnt != 5'd16) r_beat_cnt <= r_beat_cnt + 5'd1;
        r_exp_addr <= next_addr(r_exp_addr, r_size, r_burst);
      end else if (Hready && (Htrans == TR_IDLE)) begin
        r_beat_cnt <= '0;
      end

      // Remembers a completed fixed burst so a trailing SEQ reads as overrun.
      if (w_err_entry) begin
        r_done_fixed <= 1'b0;
      end else if (w_acc_seq && w_in_burst && w_seq_last) begin
        r_done_fixed <= 1'b1;
      end else if (Hready && (Htrans != TR_BUSY)) begin
        r_done_fixed <= 1'b0;
      end

      if (Hready) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_W'(MAX_WAIT + 1)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      r_prev_wait  <= !Hready && Htrans[1] && !Hresp;
      r_prev_trans <= Htrans;
      r_prev_addr  <= Haddr;
      r_prev_size  <= Hsize;
      r_prev_burst <= Hburst;
      r_prev_write <= Hwrite;
    end
  end

  assign err_vec      = r_err_vec;
  assign err_valid    = r_err_valid;
  assign err_first    = r_err_first;
  assign err_count    = r_err_count;
  assign burst_active = r_burst_active;
  assign beat_cnt     = r_beat_cnt;

endmodule
